// File: rtl/serial_nibble_rx_pkg.sv
// Shared constants for the serial nibble receiver: FSM encoding and synchronizer depth.
package serial_nibble_rx_pkg;

  localparam int SYNC_STAGES = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

endpackage

// File: rtl/serial_nibble_rx_sync_2ff.sv
// Single-bit multi-flop synchronizer for asynchronous inputs; resets to 1 (idle line level).
module sync_2ff
  import serial_nibble_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/serial_nibble_rx.sv
// Framed serial receiver (start, DATA_W bits LSB first, optional parity, stop) feeding a
// falling-edge load register through registered d/load outputs.
module serial_nibble_rx
  import serial_nibble_rx_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              sin,
  output logic [DATA_W-1:0] d,
  output logic              load,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              sin_s;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              pfail_q, pfail_d;
  logic              load_q, load_d;
  logic              ferr_q, ferr_d;
  logic              perr_q, perr_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sin),
    .q_o   (sin_s)
  );

  // Pulse outputs default low every cycle so they are exactly one clk wide.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    d_d     = d_q;
    pfail_d = pfail_q;
    load_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    if (sample_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!sin_s) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            pfail_d = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d = {sin_s, shift_q[DATA_W-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          pfail_d = (^shift_q) ^ sin_s ^ PARITY_ODD;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          // A bad stop bit outranks a parity failure.
          if (!sin_s) begin
            ferr_d = 1'b1;
          end else if (pfail_q) begin
            perr_d = 1'b1;
          end else begin
            d_d    = shift_q;
            load_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      d_q     <= '0;
      pfail_q <= 1'b0;
      load_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      d_q     <= d_d;
      pfail_q <= pfail_d;
      load_q  <= load_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  assign d          = d_q;
  assign load       = load_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Directed bench for serial_nibble_rx with a scoreboard of expected load/error events.
module tb_serial_nibble_rx;

  logic       clk;
  logic       rst_n;
  logic       sample_en;
  logic       sin;
  logic [3:0] d;
  logic       load;
  logic       busy;
  logic       frame_err;
  logic       parity_err;

  typedef struct packed {
    logic [2:0] flags;
    logic [3:0] data;
  } exp_t;

  localparam logic [2:0] EV_LOAD = 3'b001;
  localparam logic [2:0] EV_FERR = 3'b010;
  localparam logic [2:0] EV_PERR = 3'b100;

  exp_t sbq[$];
  int   loadCycles[$];
  int   total = 0;
  int   bad = 0;
  int   cycleCount = 0;
  int   busyStrobes = 0;

  serial_nibble_rx #(.DATA_W(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .sin        (sin),
    .d          (d),
    .load       (load),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic evenParity(input logic [3:0] v);
    return ^v;
  endfunction

  // Every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (load || frame_err || parity_err)) begin
      if (sbq.size() == 0) begin
        check("unexpected_pulse", {parity_err, frame_err, load}, 3'b000);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("pulse_kind", {parity_err, frame_err, load}, e.flags);
        check("pulse_d", d, e.data);
      end
      if (load) loadCycles.push_back(cycleCount);
    end
  end

  // Holds sin at b for the last cycles before a single strobe; earlier cycles may toggle.
  task automatic sendBit(input logic b, input int gap, input bit toggle);
    for (int i = 0; i < gap; i++) begin
      sin = (toggle && i < gap - 3) ? 1'($urandom_range(0, 1)) : b;
      sample_en = (i == gap - 1);
      if (i == gap - 1 && busy) busyStrobes++;
      @(negedge clk);
    end
    sample_en = 1'b0;
  endtask

  task automatic sendFrame(input logic [3:0] v, input logic par, input logic stp,
                           input int gap, input bit toggle);
    sendBit(1'b0, gap, toggle);
    for (int i = 0; i < 4; i++) sendBit(v[i], gap, toggle);
    sendBit(par, gap, toggle);
    sendBit(stp, gap, toggle);
  endtask

  task automatic streamFrame(input logic [3:0] v);
    logic [6:0] bits;
    bits = {1'b1, evenParity(v), v, 1'b0};
    for (int i = 0; i < 7; i++) begin
      sin = bits[i];
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sample_en = 1'b0;
    sin = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_d", d, 4'h0);
    check("reset_load", load, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ferr", frame_err, 1'b0);
    check("reset_perr", parity_err, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good frame 0xA, even parity.
    busyStrobes = 0;
    sbq.push_back('{EV_LOAD, 4'hA});
    sendFrame(4'hA, evenParity(4'hA), 1'b1, 4, 1'b0);
    check("frameA_busy_strobes", busyStrobes, 6);
    repeat (3) @(negedge clk);
    check("frameA_d", d, 4'hA);
    check("frameA_idle", busy, 1'b0);

    // Wrong parity on 0x7.
    sbq.push_back('{EV_PERR, 4'hA});
    sendFrame(4'h7, ~evenParity(4'h7), 1'b1, 4, 1'b0);
    repeat (3) @(negedge clk);
    check("perr_d_kept", d, 4'hA);

    // Bad stop bit on 0x3, then the line stays low and restarts a frame.
    sbq.push_back('{EV_FERR, 4'hA});
    sendFrame(4'h3, evenParity(4'h3), 1'b0, 4, 1'b0);
    sendBit(1'b0, 4, 1'b0);
    check("break_restart_busy", busy, 1'b1);
    sbq.push_back('{EV_LOAD, 4'h0});
    for (int i = 0; i < 4; i++) sendBit(1'b0, 4, 1'b0);
    sendBit(1'b0, 4, 1'b0);
    sendBit(1'b1, 4, 1'b0);
    repeat (3) @(negedge clk);
    check("break_frame_d", d, 4'h0);

    // Back-to-back frames with sample_en held high.
    loadCycles.delete();
    sbq.push_back('{EV_LOAD, 4'h5});
    sbq.push_back('{EV_LOAD, 4'hC});
    sample_en = 1'b1;
    sin = 1'b1;
    repeat (3) @(negedge clk);
    streamFrame(4'h5);
    streamFrame(4'hC);
    sin = 1'b1;
    repeat (4) @(negedge clk);
    sample_en = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_load_count", loadCycles.size(), 2);
    if (loadCycles.size() == 2)
      check("b2b_spacing", loadCycles[1] - loadCycles[0], 7);
    check("b2b_last_d", d, 4'hC);

    // Reset in the middle of a frame.
    sendBit(1'b0, 4, 1'b0);
    sendBit(1'b1, 4, 1'b0);
    sendBit(1'b0, 4, 1'b0);
    check("midframe_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset_d", d, 4'h0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_load", load, 1'b0);
    @(negedge clk);
    sin = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sbq.push_back('{EV_LOAD, 4'h9});
    sendFrame(4'h9, evenParity(4'h9), 1'b1, 4, 1'b0);
    repeat (3) @(negedge clk);
    check("after_reset_d", d, 4'h9);

    // Widely spaced strobes with a noisy line between them.
    sbq.push_back('{EV_LOAD, 4'h6});
    sendFrame(4'h6, evenParity(4'h6), 1'b1, 16, 1'b1);
    sin = 1'b1;
    repeat (3) @(negedge clk);
    check("spaced_d", d, 4'h6);
    check("spaced_load_low", load, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
